line_follow_sequencer: RTL

//  Top-level drive sequencer for the line follower. Samples the two line sensors on a

---
 rtl/line_follow_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/line_follow_sequencer.sv
// line_follow_sequencer: drive sequencer for the line follower.
// Samples the two line sensors on a periodic tick, debounces them, runs the
// FOLLOW/TURN/SEARCH/HALT state machine and drives follower_state plus left and
// right wheel speed targets toward the PID/servo path.
// Optional feature: define SPEED_RAMP_EN to slew wheel speeds by RAMP_STEP per
// tick instead of jumping straight to the target.
module line_follow_sequencer #(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned DEB_TICKS    = 4,
    parameter int unsigned SEARCH_TICKS = 2000,
    parameter logic [7:0]  SPEED_FWD    = 8'd200,
    parameter logic [7:0]  SPEED_TURN   = 8'd120,
    parameter logic [7:0]  RAMP_STEP    = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sensor,
    input  logic [1:0] sw,
    output logic [1:0] follower_state,
    output logic [7:0] Wheel_Speed_L,
    output logic [7:0] Wheel_Speed_R,
    output logic       lost,
    output logic       halted
);

    localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DebW    = $clog2(DEB_TICKS + 1);
    localparam int unsigned SearchW = (SEARCH_TICKS > 1) ? $clog2(SEARCH_TICKS) : 1;

`ifdef SPEED_RAMP_EN
    localparam bit RampEn = 1'b1;
`else
    localparam bit RampEn = 1'b0;
`endif

    // A step of 255 always lands on the target, so the non-ramp build shares the
    // same clamp logic and simply follows the target every clock.
    localparam logic [7:0] EffStep = RampEn ? RAMP_STEP : 8'd255;

    localparam logic DirLeft  = 1'b0;
    localparam logic DirRight = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StFollow,
        StTurnL,
        StTurnR,
        StSearch,
        StHalt
    } state_e;

    // Synchroniser, tick, debounce state
    logic [1:0]         sensor_meta_q;
    logic [1:0]         sensor_sync_q;
    logic [TickW-1:0]   tick_q;
    logic               tick;
    logic [1:0]         cand_q, cand_d;
    logic [DebW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [1:0]         accepted_q, accepted_d;

    // FSM state
    state_e             state_q;
    state_e             track_state;
    logic               last_dir_q;
    logic [SearchW-1:0] search_cnt_q;

    // Output targets and registers
    logic [1:0]         fs_tgt;
    logic [7:0]         tgt_l, tgt_r;
    logic               lost_tgt, halt_tgt;
    logic [1:0]         fs_q;
    logic [7:0]         speed_l_q, speed_r_q;
    logic               lost_q, halted_q;

    // Move cur toward tgt by at most step, never past the target.
    function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] step);
        if (cur < tgt) begin
            ramp_to = ((tgt - cur) > step) ? cur + step : tgt;
        end else begin
            ramp_to = ((cur - tgt) > step) ? cur - step : tgt;
        end
    endfunction

    // FOLLOW, TURN_L and TURN_R all react to the accepted pattern identically.
    function automatic state_e track_next(input logic [1:0] pat);
        case (pat)
            2'b11:   track_next = StFollow;
            2'b01:   track_next = StTurnL;
            2'b10:   track_next = StTurnR;
            default: track_next = StSearch;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous sensor pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_meta_q <= 2'b00;
            sensor_sync_q <= 2'b00;
        end else begin
            sensor_meta_q <= sensor;
            sensor_sync_q <= sensor_meta_q;
        end
    end

    assign tick = (tick_q == TickW'(TICK_DIV - 1));

    // Free-running sample tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TickW'(1);
        end
    end

    // Debounce next state; accepted_d is what the FSM sees on this tick
    always_comb begin
        cand_d     = cand_q;
        deb_cnt_d  = deb_cnt_q;
        accepted_d = accepted_q;
        if (tick) begin
            if (sensor_sync_q == cand_q) begin
                if (deb_cnt_q != DebW'(DEB_TICKS)) begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end else begin
                cand_d    = sensor_sync_q;
                deb_cnt_d = DebW'(1);
            end
            if (deb_cnt_d == DebW'(DEB_TICKS)) begin
                accepted_d = cand_d;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= 2'b00;
            deb_cnt_q  <= '0;
            accepted_q <= 2'b00;
        end else begin
            cand_q     <= cand_d;
            deb_cnt_q  <= deb_cnt_d;
            accepted_q <= accepted_d;
        end
    end

    assign track_state = track_next(accepted_d);

    // Main FSM: advances on tick, except run-disable which forces IDLE at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_dir_q   <= DirLeft;
            search_cnt_q <= '0;
        end else if (!sw[0]) begin
            state_q      <= StIdle;
            search_cnt_q <= '0;
        end else if (tick) begin
            search_cnt_q <= '0;
            unique case (state_q)
                StIdle: begin
                    state_q <= StFollow;
                end
                StFollow, StTurnL, StTurnR: begin
                    state_q <= track_state;
                    if (track_state == StTurnL) begin
                        last_dir_q <= DirLeft;
                    end else if (track_state == StTurnR) begin
                        last_dir_q <= DirRight;
                    end
                end
                StSearch: begin
                    if (accepted_d != 2'b00) begin
                        state_q <= StFollow;
                    end else if (search_cnt_q == SearchW'(SEARCH_TICKS - 1)) begin
                        state_q <= StHalt;
                    end else begin
                        search_cnt_q <= search_cnt_q + SearchW'(1);
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output targets decoded from the current state
    always_comb begin
        fs_tgt   = 2'b00;
        tgt_l    = 8'd0;
        tgt_r    = 8'd0;
        lost_tgt = 1'b0;
        halt_tgt = 1'b0;
        unique case (state_q)
            StFollow: begin
                fs_tgt = 2'b10;
                tgt_l  = SPEED_FWD;
                tgt_r  = SPEED_FWD;
            end
            StTurnL: begin
                fs_tgt = 2'b01;
                tgt_r  = SPEED_TURN;
            end
            StTurnR: begin
                fs_tgt = 2'b11;
                tgt_l  = SPEED_TURN;
            end
            StSearch: begin
                lost_tgt = 1'b1;
                if (last_dir_q == DirRight) begin
                    fs_tgt = 2'b11;
                    tgt_l  = SPEED_TURN;
                end else begin
                    fs_tgt = 2'b01;
                    tgt_r  = SPEED_TURN;
                end
            end
            StHalt: begin
                halt_tgt = 1'b1;
            end
            default: begin
                fs_tgt = 2'b00;
            end
        endcase
        if (sw[1]) begin
            tgt_l = tgt_l >> 1;
            tgt_r = tgt_r >> 1;
        end
    end

    // Registered outputs; reset and run-disable zero everything on the same edge
    always_ff @(posedge clk) begin
        if (rst || !sw[0]) begin
            fs_q      <= 2'b00;
            speed_l_q <= 8'd0;
            speed_r_q <= 8'd0;
            lost_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            fs_q     <= fs_tgt;
            lost_q   <= lost_tgt;
            halted_q <= halt_tgt;
            if (state_q == StIdle || state_q == StHalt) begin
                speed_l_q <= 8'd0;
                speed_r_q <= 8'd0;
            end else if (!RampEn || tick) begin
                speed_l_q <= ramp_to(speed_l_q, tgt_l, EffStep);
                speed_r_q <= ramp_to(speed_r_q, tgt_r, EffStep);
            end
        end
    end

    assign follower_state = fs_q;
    assign Wheel_Speed_L  = speed_l_q;
    assign Wheel_Speed_R  = speed_r_q;
    assign lost           = lost_q;
    assign halted         = halted_q;

endmodule
